// File: rtl/piece_generator.sv
// 7-bag tetromino source: LFSR-driven draws without repeats inside a bag, buffered in a
// head + preview FIFO, with the head presented as a 2x4 spawn mask.
module piece_generator #(
    parameter int                    PREVIEW_DEPTH = 3,
    parameter int                    LFSR_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         seed_load,
    input  logic [LFSR_WIDTH-1:0]        seed_in,
    input  logic                         next_req,
    output logic                         piece_valid,
    output logic [2:0]                   piece_type,
    output logic [7:0]                   piece_mask,
    output logic [3*PREVIEW_DEPTH-1:0]   preview_type,
    output logic [2:0]                   queue_count
);

    localparam int         QD   = PREVIEW_DEPTH + 1;
    localparam logic [2:0] QD_C = 3'(QD);

    logic [LFSR_WIDTH-1:0] lfsr_r;
    logic [LFSR_WIDTH-1:0] lfsr_s;
    logic [6:0]            bag_r;
    logic [6:0]            bag_s;
    logic [2:0]            queue_r [QD];
    logic [2:0]            queue_s [QD];
    logic [2:0]            count_r;
    logic [2:0]            count_s;
    logic [7:0]            mask_r;
    logic [7:0]            mask_s;

    logic                  pop_s;
    logic                  draw_s;
    logic [2:0]            post_count_s;
    logic [2:0]            cand_s;
    logic [7:0]            avail_s;
    logic [2:0]            pick_s;
    logic [6:0]            pick_oh_s;
    logic [6:0]            bag_after_s;
    logic [LFSR_WIDTH-1:0] lfsr_step_s;

    // Spawn shape for a piece type: [7:4] top row, [3:0] second row, MSB leftmost.
    function automatic logic [7:0] mask_of(input logic [2:0] t);
        logic [7:0] m;
        case (t)
            3'd1:    m = 8'h63;
            3'd2:    m = 8'h36;
            3'd3:    m = 8'hF0;
            3'd4:    m = 8'h33;
            3'd5:    m = 8'h27;
            3'd6:    m = 8'h17;
            3'd7:    m = 8'h47;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Lowest piece type still present in the bag; bit i of the bag stands for type i+1.
    function automatic logic [2:0] lowest_avail(input logic [6:0] bag);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bag[i]) begin
                res = 3'(i + 1);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Draw selection, pop/shift of the queue and next-state of every register.
    always_comb begin
        lfsr_step_s  = (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_TAPS : {LFSR_WIDTH{1'b0}});
        cand_s       = lfsr_r[2:0];
        avail_s      = {bag_r, 1'b0};
        pop_s        = next_req && (count_r != 3'd0);
        post_count_s = count_r - {2'b00, pop_s};
        draw_s       = (post_count_s < QD_C);

        // avail_s[0] is tied low so a zero candidate falls back to the lowest type
        if (avail_s[cand_s]) begin
            pick_s = cand_s;
        end else begin
            pick_s = lowest_avail(bag_r);
        end

        for (int j = 0; j < 7; j++) begin
            pick_oh_s[j] = (pick_s == 3'(j + 1));
        end
        bag_after_s = bag_r & ~pick_oh_s;

        for (int i = 0; i < QD - 1; i++) begin
            if (pop_s) begin
                queue_s[i] = queue_r[i + 1];
            end else begin
                queue_s[i] = queue_r[i];
            end
        end
        if (pop_s) begin
            queue_s[QD - 1] = 3'd0;
        end else begin
            queue_s[QD - 1] = queue_r[QD - 1];
        end
        for (int i = 0; i < QD; i++) begin
            queue_s[i] = (draw_s && (3'(i) == post_count_s)) ? pick_s : queue_s[i];
        end

        lfsr_s  = lfsr_step_s;
        count_s = post_count_s + {2'b00, draw_s};
        if (!draw_s) begin
            bag_s = bag_r;
        end else if (bag_after_s == 7'd0) begin
            bag_s = 7'b111_1111;
        end else begin
            bag_s = bag_after_s;
        end

        // A seed load flushes everything and suppresses this cycle's draw
        if (seed_load) begin
            lfsr_s  = (seed_in == {LFSR_WIDTH{1'b0}}) ? SEED : seed_in;
            bag_s   = 7'b111_1111;
            count_s = 3'd0;
            for (int i = 0; i < QD; i++) begin
                queue_s[i] = 3'd0;
            end
        end else begin
            lfsr_s = lfsr_s;
        end

        mask_s = mask_of(queue_s[0]);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r  <= SEED;
            bag_r   <= 7'b111_1111;
            count_r <= 3'd0;
            mask_r  <= 8'h00;
            for (int i = 0; i < QD; i++) begin
                queue_r[i] <= 3'd0;
            end
        end else begin
            lfsr_r  <= lfsr_s;
            bag_r   <= bag_s;
            count_r <= count_s;
            mask_r  <= mask_s;
            for (int i = 0; i < QD; i++) begin
                queue_r[i] <= queue_s[i];
            end
        end
    end

    assign piece_valid = (count_r != 3'd0);
    assign piece_type  = queue_r[0];
    assign piece_mask  = mask_r;
    assign queue_count = count_r;

    for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
        assign preview_type[3*k +: 3] = queue_r[k + 1];
    end

endmodule

// File: tb/tb_piece_generator.sv
// Directed bench for piece_generator: exact draw order from known seeds, bag
// permutation property, preview/head alignment, seed reload, async reset, mask table.
module tb_piece_generator;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        next_req;
    logic        piece_valid;
    logic [2:0]  piece_type;
    logic [7:0]  piece_mask;
    logic [8:0]  preview_type;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] t;
        logic [7:0] m;
    } mask_vec_t;

    mask_vec_t  mtab [7];
    logic [2:0] first7 [7];
    logic [2:0] rec [70];
    logic [2:0] seq_buf [14];
    logic [2:0] seq_a [14];
    logic [2:0] seq_b [14];

    piece_generator dut (
        .clk          (clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .next_req     (next_req),
        .piece_valid  (piece_valid),
        .piece_type   (piece_type),
        .piece_mask   (piece_mask),
        .preview_type (preview_type),
        .queue_count  (queue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        next_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic seed_run(input logic [15:0] s);
        int got;
        seed_load = 1'b1;
        seed_in   = s;
        next_req  = 1'b0;
        tick();
        seed_load = 1'b0;
        chk("seed_flush_count", 32'(queue_count), 32'd0);
        next_req = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 14; c++) begin
            if (piece_valid) begin
                seq_buf[got] = piece_type;
                got++;
            end
            tick();
        end
        chk("seed_run_pops", 32'(got), 32'd14);
        next_req = 1'b0;
    endtask

    initial begin
        logic [2:0] prev_p;
        logic [6:0] seen;

        mtab[0] = '{3'd1, 8'h63};
        mtab[1] = '{3'd2, 8'h36};
        mtab[2] = '{3'd3, 8'hF0};
        mtab[3] = '{3'd4, 8'h33};
        mtab[4] = '{3'd5, 8'h27};
        mtab[5] = '{3'd6, 8'h17};
        mtab[6] = '{3'd7, 8'h47};
        first7[0] = 3'd1; first7[1] = 3'd2; first7[2] = 3'd3; first7[3] = 3'd4;
        first7[4] = 3'd6; first7[5] = 3'd7; first7[6] = 3'd5;

        // Reset state and fill sequence with no pops
        rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0000; next_req = 1'b0;
        #2;
        chk("rst_valid", 32'(piece_valid), 32'd0);
        chk("rst_type",  32'(piece_type),  32'd0);
        chk("rst_mask",  32'(piece_mask),  32'd0);
        chk("rst_prev",  32'(preview_type), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("fill_count", 32'(queue_count), 32'((c < 4) ? c : 4));
            chk("fill_valid", 32'(piece_valid), 32'd1);
        end
        chk("fill_head",    32'(piece_type),   32'd1);
        chk("fill_preview", 32'(preview_type), 32'({3'd4, 3'd3, 3'd2}));
        chk("fill_mask",    32'(piece_mask),   32'h63);

        // Continuous pop from a freshly filled queue
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        next_req = 1'b1;
        for (int n = 0; n < 70; n++) begin
            rec[n] = piece_type;
            prev_p = preview_type[2:0];
            tick();
            chk("pop_count", 32'(queue_count), 32'd4);
            chk("pop_preview_align", 32'(piece_type), 32'(prev_p));
        end
        next_req = 1'b0;
        for (int i = 0; i < 7; i++) chk("first_bag_order", 32'(rec[i]), 32'(first7[i]));
        for (int g = 0; g < 10; g++) begin
            seen = 7'd0;
            for (int i = 0; i < 7; i++) begin
                if (rec[g*7 + i] != 3'd0) seen = seen | (7'd1 << (rec[g*7 + i] - 3'd1));
            end
            chk("bag_permutation", 32'(seen), 32'h7F);
        end

        // Seed reload reproducibility; empty-queue pop is ignored
        seed_load = 1'b1; seed_in = 16'h1234; tick();
        seed_load = 1'b0; next_req = 1'b1; tick();
        chk("empty_pop_count", 32'(queue_count), 32'd1);
        chk("empty_pop_head",  32'(piece_type),  32'd4);
        next_req = 1'b0;
        seed_run(16'h1234);
        for (int i = 0; i < 14; i++) seq_a[i] = seq_buf[i];
        seed_run(16'h1234);
        for (int i = 0; i < 14; i++) chk("seed_repeat", 32'(seq_buf[i]), 32'(seq_a[i]));

        // Zero seed substitutes the default seed
        seed_run(16'h0000);
        for (int i = 0; i < 14; i++) seq_a[i] = seq_buf[i];
        seed_run(16'hACE1);
        for (int i = 0; i < 14; i++) seq_b[i] = seq_buf[i];
        for (int i = 0; i < 14; i++) chk("seed_zero_eq", 32'(seq_a[i]), 32'(seq_b[i]));
        for (int i = 0; i < 7; i++) chk("seed_default_order", 32'(seq_b[i]), 32'(first7[i]));

        // Asynchronous reset between edges
        next_req = 1'b1;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(piece_valid), 32'd0);
        chk("async_type",  32'(piece_type),  32'd0);
        chk("async_mask",  32'(piece_mask),  32'd0);
        chk("async_prev",  32'(preview_type), 32'd0);
        chk("async_count", 32'(queue_count), 32'd0);
        next_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Mask table: pop until each type reaches the head
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int c = 0; c < 4; c++) tick();
            next_req = 1'b1;
            for (int c = 0; c < 12 && piece_type != mtab[v].t; c++) tick();
            next_req = 1'b0;
            chk("mask_head_type", 32'(piece_type), 32'(mtab[v].t));
            tick();
            chk("mask_value", 32'(piece_mask), 32'(mtab[v].m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
